// File: rtl/l2_cache_responder.sv
// l2_cache_responder: direct-mapped, write-back L2 cache between an L1 line
// interface and a slow line-oriented memory.
// Optional feature macro: L2_PERF_CNT_EN adds the hit_cnt/miss_cnt outputs.
// Tags and data are kept in arrays with combinational lookup. This lets the
// COMPARE state decide on the tag it sees in that same cycle, which keeps the
// hit path at two cycles. Valid and dirty bits are kept in flops so that a
// reset can clear them all in one cycle.
module l2_cache_responder #(
    parameter int L2_LINES = 64
) (
    input  logic           clk,
    input  logic           proc_reset,
    input  logic           mem_read,
    input  logic           mem_write,
    input  logic [31:4]    mem_addr,
    input  logic [127:0]   mem_wdata,
    output logic [127:0]   mem_rdata,
    output logic           mem_ready,
    output logic           l2_mem_read,
    output logic           l2_mem_write,
    output logic [31:4]    l2_mem_addr,
    output logic [127:0]   l2_mem_wdata,
    input  logic [127:0]   l2_mem_rdata,
    input  logic           l2_mem_ready
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]    hit_cnt,
    output logic [31:0]    miss_cnt
`endif
);

    localparam int IDX_W = $clog2(L2_LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        RESPOND
    } state_t;

    state_t               r_state;
    logic [31:4]          r_addr;
    logic [127:0]         r_wdata;
    logic                 r_is_write;
    logic [L2_LINES-1:0]  r_valid;
    logic [L2_LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]     r_tag_mem  [L2_LINES];
    logic [127:0]         r_data_mem [L2_LINES];
`ifdef L2_PERF_CNT_EN
    logic                 r_first;
`endif

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_line_valid;
    logic                 w_line_dirty;
    logic [TAG_W-1:0]     w_line_tag;
    logic [127:0]         w_line_data;
    logic                 w_hit;
    logic                 w_arr_we;
    logic [127:0]         w_arr_data;

    assign w_idx        = r_addr[IDX_W+3:4];
    assign w_tag        = r_addr[31:IDX_W+4];
    assign w_line_valid = r_valid[w_idx];
    assign w_line_dirty = r_dirty[w_idx];
    assign w_line_tag   = r_tag_mem[w_idx];
    assign w_line_data  = r_data_mem[w_idx];
    assign w_hit        = w_line_valid && (w_line_tag == w_tag);

    // Array write port: a write hit, a write miss whose victim is clean, or a fill from memory.
    always_comb begin
        w_arr_we   = 1'b0;
        w_arr_data = r_wdata;
        if (!proc_reset) begin
            case (r_state)
                COMPARE: begin
                    if (r_is_write && (w_hit || !(w_line_valid && w_line_dirty)))
                        w_arr_we = 1'b1;
                end
                ALLOCATE: begin
                    if (l2_mem_ready) begin
                        w_arr_we   = 1'b1;
                        w_arr_data = l2_mem_rdata;
                    end
                end
                default: w_arr_we = 1'b0;
            endcase
        end
    end

    // Tag and data storage. This storage has no reset; the valid bits decide whether a line counts.
    always_ff @(posedge clk) begin
        if (w_arr_we) begin
            r_tag_mem[w_idx]  <= w_tag;
            r_data_mem[w_idx] <= w_arr_data;
        end
    end

    // Controller FSM. It drives the registered handshake outputs and the valid and dirty bits.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            mem_ready    <= 1'b0;
            mem_rdata    <= '0;
            l2_mem_read  <= 1'b0;
            l2_mem_write <= 1'b0;
            l2_mem_addr  <= '0;
            l2_mem_wdata <= '0;
`ifdef L2_PERF_CNT_EN
            r_first      <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
`endif
        end else begin
            mem_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mem_write || mem_read) begin
                        r_addr     <= mem_addr;
                        r_wdata    <= mem_wdata;
                        r_is_write <= mem_write;
`ifdef L2_PERF_CNT_EN
                        r_first    <= 1'b1;
`endif
                        r_state    <= COMPARE;
                    end
                end
                COMPARE: begin
`ifdef L2_PERF_CNT_EN
                    // Count only the first lookup. A lookup repeated after a writeback or fill is not counted.
                    if (r_first) begin
                        if (w_hit) hit_cnt  <= hit_cnt + 32'd1;
                        else       miss_cnt <= miss_cnt + 32'd1;
                        r_first <= 1'b0;
                    end
`endif
                    if (w_hit) begin
                        if (r_is_write) r_dirty[w_idx] <= 1'b1;
                        else            mem_rdata      <= w_line_data;
                        mem_ready <= 1'b1;
                        r_state   <= RESPOND;
                    end else if (w_line_valid && w_line_dirty) begin
                        l2_mem_write <= 1'b1;
                        l2_mem_addr  <= {w_line_tag, w_idx};
                        l2_mem_wdata <= w_line_data;
                        r_state      <= WRITEBACK;
                    end else if (r_is_write) begin
                        // A whole-line write needs no fetch. The line is installed already dirty.
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b1;
                        mem_ready      <= 1'b1;
                        r_state        <= RESPOND;
                    end else begin
                        l2_mem_read <= 1'b1;
                        l2_mem_addr <= r_addr;
                        r_state     <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (l2_mem_ready) begin
                        l2_mem_write   <= 1'b0;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= COMPARE;
                    end
                end
                ALLOCATE: begin
                    if (l2_mem_ready) begin
                        l2_mem_read    <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= COMPARE;
                    end
                end
                RESPOND: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_cache_responder.sv
// Directed testbench for l2_cache_responder. A small slow-memory responder is
// built into the request task.
module tb_l2_cache_responder;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [31:4]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         l2_mem_read;
    logic         l2_mem_write;
    logic [31:4]  l2_mem_addr;
    logic [127:0] l2_mem_wdata;
    logic [127:0] l2_mem_rdata;
    logic         l2_mem_ready;
`ifdef L2_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    always #5 clk = ~clk;

    l2_cache_responder #(.L2_LINES(64)) dut (
        .clk          (clk),
        .proc_reset   (proc_reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .l2_mem_read  (l2_mem_read),
        .l2_mem_write (l2_mem_write),
        .l2_mem_addr  (l2_mem_addr),
        .l2_mem_wdata (l2_mem_wdata),
        .l2_mem_rdata (l2_mem_rdata),
        .l2_mem_ready (l2_mem_ready)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
`endif
    );

    int           n_chk = 0;
    int           n_fail = 0;
    int           r_cyc;
    int           n_rd;
    int           n_wr;
    int           overlap = 0;
    int           stable_err = 0;
    logic         got;
    logic [127:0] r_data;
    logic         lg_wr   [4];
    logic [27:0]  lg_addr [4];
    logic [127:0] lg_data [4];

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_11 = {16{8'h11}};
    localparam logic [127:0] D_C3 = {16{8'hC3}};
    localparam logic [127:0] D_5A = {16{8'h5A}};
    localparam logic [127:0] D_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one L1 request and serve slow-memory accesses (ready 3 cycles after request) until mem_ready.
    task automatic run_req(input logic rd, input logic wr, input logic [27:0] a,
                           input logic [127:0] wd, input logic [127:0] resp);
        int pend;
        int cyc;
        int k;
        logic [27:0]  sa;
        logic [127:0] sd;
        n_rd = 0; n_wr = 0; got = 1'b0; r_cyc = -1; pend = 0; cyc = 0;
        sa = '0; sd = '0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_read = 1'b0; mem_write = 1'b0; l2_mem_ready = 1'b0;
            if (mem_ready) begin
                got = 1'b1; r_cyc = cyc; r_data = mem_rdata;
            end
            if (l2_mem_read && l2_mem_write) overlap++;
            if (l2_mem_read || l2_mem_write) begin
                if (pend == 0) begin
                    sa = l2_mem_addr; sd = l2_mem_wdata;
                end else if (sa !== l2_mem_addr || sd !== l2_mem_wdata) begin
                    stable_err++;
                end
                pend++;
                if (pend == 3) begin
                    k = n_rd + n_wr;
                    if (k < 4) begin
                        lg_wr[k] = l2_mem_write; lg_addr[k] = l2_mem_addr; lg_data[k] = l2_mem_wdata;
                    end
                    if (l2_mem_write) n_wr++; else n_rd++;
                    l2_mem_rdata = resp;
                    l2_mem_ready = 1'b1;
                    pend = 0;
                end
            end else begin
                pend = 0;
            end
        end
        chk("req_completed", got, 1'b1);
        @(negedge clk);
        l2_mem_ready = 1'b0;
        chk("ready_one_cycle", mem_ready, 1'b0);
        $display("req rd=%0b wr=%0b addr=%h: ready at cycle %0d, rdata=%h, l2 reads=%0d writes=%0d",
                 rd, wr, a, r_cyc, r_data, n_rd, n_wr);
    endtask

    initial begin
        int seen;
        proc_reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
        mem_wdata = '0; l2_mem_rdata = '0; l2_mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_l2_read", l2_mem_read, 1'b0);
        chk("rst_l2_write", l2_mem_write, 1'b0);
        chk("rst_l2_addr", l2_mem_addr, 28'h0);
        chk("rst_l2_wdata", l2_mem_wdata, 128'h0);
        chk("rst_rdata", mem_rdata, 128'h0);
`ifdef L2_PERF_CNT_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        proc_reset = 1'b0;

        // Cold read miss: the line is fetched from slow memory.
        run_req(1'b1, 1'b0, 28'h0000100, '0, D_A5);
        chk("cold_n_rd", n_rd, 1);
        chk("cold_n_wr", n_wr, 0);
        chk("cold_l2_addr", lg_addr[0], 28'h0000100);
        chk("cold_rdata", r_data, D_A5);

        // Read hit: the response comes two cycles after the request.
        run_req(1'b1, 1'b0, 28'h0000100, '0, '0);
        chk("hit_latency", r_cyc, 2);
        chk("hit_no_mem", n_rd + n_wr, 0);
        chk("hit_rdata", r_data, D_A5);

        // Write miss with a clean victim: the line is installed with no memory access.
        run_req(1'b0, 1'b1, 28'h0000200, D_11, '0);
        chk("wmiss_latency", r_cyc, 2);
        chk("wmiss_no_mem", n_rd + n_wr, 0);
        run_req(1'b1, 1'b0, 28'h0000200, '0, '0);
        chk("wmiss_readback", r_data, D_11);
        chk("wmiss_rb_latency", r_cyc, 2);

        // Dirty eviction: the victim is written back, then the new line is fetched.
        run_req(1'b1, 1'b0, 28'h0001200, '0, D_C3);
        chk("evict_n_wr", n_wr, 1);
        chk("evict_n_rd", n_rd, 1);
        chk("evict_first_is_wr", lg_wr[0], 1'b1);
        chk("evict_wb_addr", lg_addr[0], 28'h0000200);
        chk("evict_wb_data", lg_data[0], D_11);
        chk("evict_second_is_rd", lg_wr[1], 1'b0);
        chk("evict_fill_addr", lg_addr[1], 28'h0001200);
        chk("evict_rdata", r_data, D_C3);
`ifdef L2_PERF_CNT_EN
        chk("cnt_hit", hit_cnt, 32'd2);
        chk("cnt_miss", miss_cnt, 32'd3);
`endif

        // Reset arrives while a fill is pending.
        @(negedge clk);
        mem_read = 1'b1; mem_addr = 28'h0000110;
        @(negedge clk);
        mem_read = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (l2_mem_read) seen = 1;
            else @(negedge clk);
        end
        chk("alloc_reached", seen, 1);
        proc_reset = 1'b1;
        @(negedge clk);
        chk("rst_abort_l2_read", l2_mem_read, 1'b0);
        chk("rst_abort_ready", mem_ready, 1'b0);
`ifdef L2_PERF_CNT_EN
        chk("rst_abort_hit_cnt", hit_cnt, 32'd0);
        chk("rst_abort_miss_cnt", miss_cnt, 32'd0);
`endif
        proc_reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_ready || l2_mem_read || l2_mem_write) seen++;
        end
        chk("rst_abort_quiet", seen, 0);

        // After the reset the same address misses again, and the earlier lines are gone.
        run_req(1'b1, 1'b0, 28'h0000110, '0, D_5A);
        chk("post_rst_miss_rd", n_rd, 1);
        chk("post_rst_rdata", r_data, D_5A);
        run_req(1'b1, 1'b0, 28'h0001200, '0, D_C3);
        chk("post_rst_no_wb", n_wr, 0);
        chk("post_rst_refetch", n_rd, 1);

        // When read and write are asserted together, the write wins.
        run_req(1'b1, 1'b1, 28'h0000220, D_PAT, D_A5);
        chk("both_is_write_no_mem", n_rd + n_wr, 0);
        chk("both_latency", r_cyc, 2);

        // A stray l2_mem_ready while idle must be ignored.
        @(negedge clk);
        l2_mem_ready = 1'b1;
        @(negedge clk);
        l2_mem_ready = 1'b0;
        chk("stray_ready_no_resp", mem_ready, 1'b0);
        run_req(1'b1, 1'b0, 28'h0000220, '0, '0);
        chk("both_readback", r_data, D_PAT);
        chk("both_rb_hit", n_rd + n_wr, 0);

        chk("no_rd_wr_overlap", overlap, 0);
        chk("l2_req_stable", stable_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
